// File: rtl/serial_sub_pkg.sv
// Shared types for the bit-serial subtractor: FSM state encoding.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

endpackage

// File: rtl/half_sub_case.sv
// Half-subtractor A - B coded as a truth-table case: difference D, borrow Bo.
module half_sub_case (
  input  logic A,
  input  logic B,
  output logic D,
  output logic Bo
);

  always_comb begin
    D  = 1'b0;
    Bo = 1'b0;
    case ({A, B})
      2'b00: begin D = 1'b0; Bo = 1'b0; end
      2'b01: begin D = 1'b1; Bo = 1'b1; end
      2'b10: begin D = 1'b1; Bo = 1'b0; end
      2'b11: begin D = 1'b0; Bo = 1'b0; end
      default: begin D = 1'b0; Bo = 1'b0; end
    endcase
  end

endmodule

// File: rtl/serial_sub_fsm.sv
// Bit-serial X - Y, LSB first, one bit per clock, with START/BUSY/DONE handshake.
module serial_sub_fsm
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] D,
  output logic             BO
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  // Terminal count sized to the counter itself, so WIDTH=32 compares against 5'd31.
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t state, state_nxt;

  logic [WIDTH-1:0] xs;
  logic [WIDTH-1:0] ys;
  logic [WIDTH-1:0] ds;
  logic [CW-1:0]    cnt;
  logic             borrow;

  logic d1, b1, dbit, b2;

  half_sub_case u_hs1 (
    .A  (xs[0]),
    .B  (ys[0]),
    .D  (d1),
    .Bo (b1)
  );

  half_sub_case u_hs2 (
    .A  (d1),
    .B  (borrow),
    .D  (dbit),
    .Bo (b2)
  );

  always_ff @(posedge CLK) begin
    if (!RST_N) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    BUSY      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (START) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        BUSY = 1'b1;
        if (cnt == CNT_LAST) state_nxt = ST_FINISH;
      end
      ST_FINISH: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      xs     <= '0;
      ys     <= '0;
      ds     <= '0;
      cnt    <= '0;
      borrow <= 1'b0;
      D      <= '0;
      BO     <= 1'b0;
      DONE   <= 1'b0;
    end else begin
      DONE <= (state == ST_FINISH);
      case (state)
        ST_IDLE: begin
          if (START) begin
            xs     <= X;
            ys     <= Y;
            borrow <= 1'b0;
            cnt    <= '0;
          end
        end
        ST_RUN: begin
          ds     <= {dbit, ds[WIDTH-1:1]};
          xs     <= xs >> 1;
          ys     <= ys >> 1;
          borrow <= b1 | b2;
          cnt    <= cnt + CW'(1);
        end
        ST_FINISH: begin
          D  <= ds;
          BO <= borrow;
        end
        default: ;
      endcase
    end
  end

endmodule
